multi_port_mem_requester: RTL and testbench

//   Initiator side of the flat-vector multi-port memory interface (we/waddr/wdata, re/raddr/rdata).

---
 rtl/multi_port_mem_requester_if.sv | 41 ++++
 rtl/multi_port_mem_requester.sv | 210 +++++++++++++++++++++
 tb/tb_multi_port_mem_requester.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_port_mem_requester_if.sv
// Bundles the client request/response streams and the flat-vector memory
// port signals between multi_port_mem_requester and its surroundings.
//   master : the requester (arbitrates clients, drives memory ports)
//   slave  : clients plus memory (drive requests, rsp_ready and rdata)
// Signals
//   req_valid/req_ready/req_we/req_addr/req_wdata : client request streams
//   rsp_valid/rsp_ready/rsp_data                  : client read responses
//   we/waddr/wdata                                : memory write ports
//   re/raddr/rdata                                : memory read ports
interface multi_port_mem_requester_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_CLIENTS     = 4
);
  logic [NUM_CLIENTS-1:0]                 req_valid;
  logic [NUM_CLIENTS-1:0]                 req_ready;
  logic [NUM_CLIENTS-1:0]                 req_we;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]      req_addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0]      req_wdata;
  logic [NUM_CLIENTS-1:0]                 rsp_valid;
  logic [NUM_CLIENTS-1:0]                 rsp_ready;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0]      rsp_data;
  logic [NUM_WRITE_PORTS-1:0]             we;
  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0]  waddr;
  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0]  wdata;
  logic [NUM_READ_PORTS-1:0]              re;
  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]   raddr;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, rdata,
    output req_ready, rsp_valid, rsp_data, we, waddr, wdata, re, raddr
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, rdata,
    input  req_ready, rsp_valid, rsp_data, we, waddr, wdata, re, raddr
  );
endinterface

// File: rtl/multi_port_mem_requester.sv
// Initiator side of a flat-vector multi-port memory. Each cycle the client
// requests are scanned round-robin and placed onto free write/read ports,
// avoiding same-cycle write/write and write/read address collisions. Each
// read port carries a tag so the data returning one cycle later lands in the
// issuing client's one-entry response slot.
// Ports
//   clk  : clock, all state on posedge
//   rst  : asynchronous reset, active-high
//   bus  : master side of multi_port_mem_requester_if (client streams and
//          memory ports; memory outputs are combinational from the grant)
module multi_port_mem_requester #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_CLIENTS     = 4
) (
  input logic                        clk,
  input logic                        rst,
  multi_port_mem_requester_if.master bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int NW = NUM_WRITE_PORTS;
  localparam int NR = NUM_READ_PORTS;
  localparam int NC = NUM_CLIENTS;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  logic [CW-1:0]          rr_ptr_r;
  logic [CW-1:0]          rr_next_s;
  logic [NR-1:0]          tag_valid_r;
  logic [NR-1:0][CW-1:0]  tag_idx_r;
  logic [NR-1:0][CW-1:0]  tag_idx_s;
  logic [NC-1:0]          rsp_valid_r;
  logic [NC*DW-1:0]       rsp_data_r;
  logic [NC-1:0]          inflight_s;
  logic [NC*DW-1:0]       load_data_s;
  logic [NC-1:0]          grant_s;
  logic [NW-1:0]          we_s;
  logic [NW*AW-1:0]       waddr_s;
  logic [NW*DW-1:0]       wdata_s;
  logic [NR-1:0]          re_s;
  logic [NR*AW-1:0]       raddr_s;
  logic                   wr_take_s;
  logic                   rd_take_s;
  logic [AW-1:0]          cand_addr_s;
  int                     wr_cnt_s;
  int                     rd_cnt_s;
  int                     last_c_s;

  // Client index visited at scan position k, starting at the RR pointer.
  function automatic int scan_client(input logic [CW-1:0] ptr, input int k);
    return (int'(ptr) + k) % NC;
  endfunction

  // True when address a matches any enabled write port.
  function automatic logic addr_hit(input logic [NW-1:0] en,
                                    input logic [NW*AW-1:0] addrs,
                                    input logic [AW-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NW; p++) begin
      hit = hit | (en[p] & (addrs[p*AW +: AW] == a));
    end
    return hit;
  endfunction

  // Route each read port's returning data to the client named by its tag.
  always_comb begin
    inflight_s  = '0;
    load_data_s = '0;
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NR; p++) begin
        if (tag_valid_r[p] && (tag_idx_r[p] == CW'(c))) begin
          inflight_s[c]             = 1'b1;
          load_data_s[c*DW +: DW]   = bus.rdata[p*DW +: DW];
        end else begin
          inflight_s[c]             = inflight_s[c];
        end
      end
    end
  end

  // Round-robin grant: all writes first so that every read can be checked
  // against the complete set of addresses written this cycle.
  always_comb begin
    grant_s     = '0;
    we_s        = '0;
    waddr_s     = '0;
    wdata_s     = '0;
    re_s        = '0;
    raddr_s     = '0;
    tag_idx_s   = '0;
    wr_cnt_s    = 0;
    rd_cnt_s    = 0;
    wr_take_s   = 1'b0;
    rd_take_s   = 1'b0;
    cand_addr_s = '0;
    for (int k = 0; k < NC; k++) begin
      for (int c = 0; c < NC; c++) begin
        if (c == scan_client(rr_ptr_r, k)) begin
          cand_addr_s = bus.req_addr[c*AW +: AW];
          wr_take_s   = !rst && bus.req_valid[c] && bus.req_we[c] &&
                        (wr_cnt_s < NW) && !addr_hit(we_s, waddr_s, cand_addr_s);
          for (int p = 0; p < NW; p++) begin
            if (wr_take_s && (p == wr_cnt_s)) begin
              we_s[p]              = 1'b1;
              waddr_s[p*AW +: AW]  = cand_addr_s;
              wdata_s[p*DW +: DW]  = bus.req_wdata[c*DW +: DW];
            end else begin
              we_s[p]              = we_s[p];
            end
          end
          if (wr_take_s) begin
            grant_s[c] = 1'b1;
            wr_cnt_s   = wr_cnt_s + 1;
          end else begin
            grant_s[c] = grant_s[c];
          end
        end else begin
          wr_take_s = 1'b0;
        end
      end
    end
    for (int k = 0; k < NC; k++) begin
      for (int c = 0; c < NC; c++) begin
        if (c == scan_client(rr_ptr_r, k)) begin
          cand_addr_s = bus.req_addr[c*AW +: AW];
          // One outstanding read per client: slot must be empty and no tag live.
          rd_take_s   = !rst && bus.req_valid[c] && !bus.req_we[c] &&
                        (rd_cnt_s < NR) && !rsp_valid_r[c] && !inflight_s[c] &&
                        !addr_hit(we_s, waddr_s, cand_addr_s);
          for (int p = 0; p < NR; p++) begin
            if (rd_take_s && (p == rd_cnt_s)) begin
              re_s[p]              = 1'b1;
              raddr_s[p*AW +: AW]  = cand_addr_s;
              tag_idx_s[p]         = CW'(c);
            end else begin
              re_s[p]              = re_s[p];
            end
          end
          if (rd_take_s) begin
            grant_s[c] = 1'b1;
            rd_cnt_s   = rd_cnt_s + 1;
          end else begin
            grant_s[c] = grant_s[c];
          end
        end else begin
          rd_take_s = 1'b0;
        end
      end
    end
  end

  // Next RR pointer: one past the last client granted in scan order.
  always_comb begin
    last_c_s = 0;
    for (int k = 0; k < NC; k++) begin
      for (int c = 0; c < NC; c++) begin
        if ((c == scan_client(rr_ptr_r, k)) && grant_s[c]) begin
          last_c_s = c;
        end else begin
          last_c_s = last_c_s;
        end
      end
    end
    rr_next_s = CW'((last_c_s + 1) % NC);
  end

  // RR pointer and per-read-port tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      tag_valid_r <= '0;
      tag_idx_r   <= '0;
    end else begin
      if (|grant_s) begin
        rr_ptr_r <= rr_next_s;
      end
      tag_valid_r <= re_s;
      tag_idx_r   <= tag_idx_s;
    end
  end

  // Response slots: fill from tagged read data, drain on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (inflight_s[c]) begin
          rsp_valid_r[c]         <= 1'b1;
          rsp_data_r[c*DW +: DW] <= load_data_s[c*DW +: DW];
        end else if (rsp_valid_r[c] && bus.rsp_ready[c]) begin
          rsp_valid_r[c]         <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.we        = we_s;
  assign bus.waddr     = waddr_s;
  assign bus.wdata     = wdata_s;
  assign bus.re        = re_s;
  assign bus.raddr     = raddr_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
endmodule

// File: tb/tb_multi_port_mem_requester.sv
// Bench for multi_port_mem_requester: directed scenarios, a memory responder,
// a set-based model of the arbitration and response timing checked every
// cycle, and hand-computed literal expectations for each scenario.
module tb_multi_port_mem_requester;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NW = 4;
  localparam int NR = 2;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_port_mem_requester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WRITE_PORTS(NW),
                                .NUM_READ_PORTS(NR), .NUM_CLIENTS(NC)) bus ();

  multi_port_mem_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WRITE_PORTS(NW),
                             .NUM_READ_PORTS(NR), .NUM_CLIENTS(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: registered read data one cycle after re, writes commit at the edge.
  logic [DW-1:0] mem_arr [0:15];
  always @(posedge clk) begin
    for (int p = 0; p < NR; p++)
      if (bus.re[p]) bus.rdata[p*DW +: DW] <= mem_arr[bus.raddr[p*AW +: AW]];
    for (int p = 0; p < NW; p++)
      if (bus.we[p]) mem_arr[bus.waddr[p*AW +: AW]] <= bus.wdata[p*DW +: DW];
  end

  // Model state
  logic [DW-1:0] m_mem [0:15];
  logic [NC-1:0] m_pend;
  logic [DW-1:0] m_data [NC];
  int            m_rdy [NC];
  int            m_rr;
  int            cyc;
  logic [DW-1:0] got_data [NC];
  int            got_cnt [NC];

  // Model + compare, evaluated on every falling edge.
  initial begin
    logic [NC-1:0]    e_ready, e_rv;
    logic [NW-1:0]    e_we;
    logic [NW*AW-1:0] e_waddr;
    logic [NW*DW-1:0] e_wdata;
    logic [NR-1:0]    e_re;
    logic [NR*AW-1:0] e_raddr;
    logic [15:0]      wset;
    logic [AW-1:0]    a;
    int wu, ru, last_c, c;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < NC; i++) begin
      m_data[i] = 8'h00; m_rdy[i] = 0; got_data[i] = 8'h00; got_cnt[i] = 0;
    end
    m_pend = '0; m_rr = 0; cyc = 0;
    forever begin
      @(negedge clk);
      e_ready = '0; e_rv = '0; e_we = '0; e_waddr = '0; e_wdata = '0;
      e_re = '0; e_raddr = '0; wset = 16'h0000; wu = 0; ru = 0; last_c = -1;
      if (!rst) begin
        for (int i = 0; i < NC; i++) e_rv[i] = m_pend[i] && (cyc >= m_rdy[i]);
        for (int k = 0; k < NC; k++) begin
          c = (m_rr + k) % NC;
          a = bus.req_addr[c*AW +: AW];
          if (bus.req_valid[c] && bus.req_we[c] && wu < NW && !wset[a]) begin
            e_ready[c] = 1'b1; e_we[wu] = 1'b1;
            e_waddr[wu*AW +: AW] = a; e_wdata[wu*DW +: DW] = bus.req_wdata[c*DW +: DW];
            wset[a] = 1'b1; wu++;
          end
        end
        for (int k = 0; k < NC; k++) begin
          c = (m_rr + k) % NC;
          a = bus.req_addr[c*AW +: AW];
          if (bus.req_valid[c] && !bus.req_we[c] && ru < NR && !m_pend[c] && !wset[a]) begin
            e_ready[c] = 1'b1; e_re[ru] = 1'b1; e_raddr[ru*AW +: AW] = a; ru++;
          end
        end
        for (int k = 0; k < NC; k++) begin
          c = (m_rr + k) % NC;
          if (e_ready[c]) last_c = c;
        end
      end
      check("req_ready", 32'(bus.req_ready), 32'(e_ready));
      check("we", 32'(bus.we), 32'(e_we));
      check("re", 32'(bus.re), 32'(e_re));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      for (int p = 0; p < NW; p++)
        if (e_we[p]) begin
          check("waddr", 32'(bus.waddr[p*AW +: AW]), 32'(e_waddr[p*AW +: AW]));
          check("wdata", 32'(bus.wdata[p*DW +: DW]), 32'(e_wdata[p*DW +: DW]));
        end
      for (int p = 0; p < NR; p++)
        if (e_re[p]) check("raddr", 32'(bus.raddr[p*AW +: AW]), 32'(e_raddr[p*AW +: AW]));
      for (int i = 0; i < NC; i++)
        if (e_rv[i]) check("rsp_data", 32'(bus.rsp_data[i*DW +: DW]), 32'(m_data[i]));
      // Log delivered responses for the literal checks.
      for (int i = 0; i < NC; i++)
        if (!rst && bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          got_data[i] = bus.rsp_data[i*DW +: DW]; got_cnt[i]++;
        end
      // Advance the model.
      if (rst) begin
        m_pend = '0; m_rr = 0;
      end else begin
        for (int i = 0; i < NC; i++) if (e_rv[i] && bus.rsp_ready[i]) m_pend[i] = 1'b0;
        for (int i = 0; i < NC; i++)
          if (e_ready[i] && !bus.req_we[i]) begin
            m_pend[i] = 1'b1; m_data[i] = m_mem[bus.req_addr[i*AW +: AW]]; m_rdy[i] = cyc + 2;
          end
        for (int i = 0; i < NC; i++)
          if (e_ready[i] && bus.req_we[i]) m_mem[bus.req_addr[i*AW +: AW]] = bus.req_wdata[i*DW +: DW];
        if (last_c >= 0) m_rr = (last_c + 1) % NC;
      end
      cyc++;
    end
  end

  logic [NC-1:0] hist [0:15];
  logic [NW-1:0] we_hist [0:15];
  int            hist_n;

  task automatic set_req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[c] = 1'b1;
    bus.req_we[c] = w;
    bus.req_addr[c*AW +: AW] = a;
    bus.req_wdata[c*DW +: DW] = d;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hold requests until granted, logging req_ready/we per cycle.
  task automatic run_reqs(input int budget);
    logic [NC-1:0] g;
    int n;
    n = 0; hist_n = 0;
    while (bus.req_valid != '0 && n < budget) begin
      @(negedge clk); #1;
      g = bus.req_ready & bus.req_valid;
      if (hist_n < 16) begin hist[hist_n] = bus.req_ready; we_hist[hist_n] = bus.we; hist_n++; end
      @(posedge clk); #1;
      bus.req_valid = bus.req_valid & ~g;
      n++;
    end
    n_cmp++;
    if (bus.req_valid != '0) begin
      n_mis++;
      $display("FAIL grant_timeout: still pending %0h expected 0", bus.req_valid);
      bus.req_valid = '0;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt2;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 4'b1111;
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h0000_0000);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 1: idle
    step(1);
    @(negedge clk); #1;
    check("idle_we", 32'(bus.we), 32'h0);
    check("idle_re", 32'(bus.re), 32'h0);
    check("idle_req_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;

    // 2: four writes in one cycle, then read them back
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, 4'(c + 1), 8'hA0 + 8'(c));
    run_reqs(10);
    check("wr4_ready", 32'(hist[0]), 32'hF);
    check("wr4_we", 32'(we_hist[0]), 32'hF);
    check("wr4_cycles", 32'(hist_n), 32'd1);
    // 5: four reads over two read ports
    for (int c = 0; c < NC; c++) set_req(c, 1'b0, 4'(c + 1), 8'h00);
    run_reqs(10);
    check("rd_grant0", 32'(hist[0]), 32'h3);
    check("rd_grant1", 32'(hist[1]), 32'hC);
    step(4);
    for (int c = 0; c < NC; c++) check("rd_data", 32'(got_data[c]), 32'hA0 + 32'(c));

    // 3: write/write hazard on addr 5
    set_req(0, 1'b1, 4'd5, 8'h11);
    set_req(1, 1'b1, 4'd5, 8'h22);
    run_reqs(10);
    check("ww_grant0", 32'(hist[0]), 32'h1);
    check("ww_grant1", 32'(hist[1]), 32'h2);
    set_req(0, 1'b0, 4'd5, 8'h00);
    run_reqs(10);
    step(4);
    check("ww_read", 32'(got_data[0]), 32'h22);

    // 4: same-cycle write and read of addr 7
    set_req(2, 1'b1, 4'd7, 8'h5A);
    set_req(3, 1'b0, 4'd7, 8'h00);
    run_reqs(10);
    check("wr_rd_grant0", 32'(hist[0]), 32'h4);
    check("wr_rd_grant1", 32'(hist[1]), 32'h8);
    step(4);
    check("wr_rd_data", 32'(got_data[3]), 32'h5A);

    // 6: back-pressured response slot
    bus.rsp_ready[1] = 1'b0;
    set_req(1, 1'b0, 4'd2, 8'h00);
    run_reqs(10);
    step(1);
    set_req(1, 1'b0, 4'd3, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("hold_ready", 32'(bus.req_ready[1]), 32'h0);
      check("hold_valid", 32'(bus.rsp_valid[1]), 32'h1);
      check("hold_data", 32'(bus.rsp_data[15:8]), 32'hA1);
      @(posedge clk); #1;
    end
    bus.rsp_ready[1] = 1'b1;
    run_reqs(10);
    step(4);
    check("after_hold_data", 32'(got_data[1]), 32'hA2);

    // 6: reset with one response held and one read in flight
    bus.rsp_ready[0] = 1'b0;
    set_req(0, 1'b0, 4'd1, 8'h00);
    run_reqs(10);
    step(1);
    set_req(2, 1'b0, 4'd3, 8'h00);
    run_reqs(10);
    cnt0 = got_cnt[0];
    cnt2 = got_cnt[2];
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready[0] = 1'b1;
    step(4);
    check("midrst_no_late0", 32'(got_cnt[0]), 32'(cnt0));
    check("midrst_no_late2", 32'(got_cnt[2]), 32'(cnt2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
